// File: rtl/sha256_msg_padder.sv
// SHA-256 input FIFO writer: streams message words into the engine FIFO, then appends
// the 0x80 marker, zero fill and 64-bit bit length so the FIFO only ever holds whole blocks.
module sha256_msg_padder #(
  parameter int BYTE_CNT_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        empty_msg_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] blocks_o,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_dat_i,
  input  logic        in_last_i,
  input  logic [1:0]  in_bytes_i,
  input  logic        fifo_full_i,
  output logic        fifo_wr_en_o,
  output logic [31:0] fifo_wr_dat_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_PAD80, S_ZERO, S_LENHI, S_LENLO
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [3:0]            r_widx;
  logic [15:0]           r_blocks;
  logic                  r_done;
  logic                  w_accept;
  logic                  w_wr_en;
  logic [31:0]           w_wr_dat;
  logic                  w_ready;
  logic [2:0]            w_byte_inc;
  logic [63:0]           w_bit_len;

  // Keep the n valid leading bytes of a short final word and place the marker right after them.
  function automatic logic [31:0] mark_last(input logic [31:0] dat, input logic [1:0] n);
    logic [31:0] res;
    case (n)
      2'd1:    res = {dat[31:24], 24'h800000};
      2'd2:    res = {dat[31:16], 16'h8000};
      2'd3:    res = {dat[31:8],  8'h80};
      default: res = dat;
    endcase
    return res;
  endfunction

  assign w_bit_len  = {{(64-BYTE_CNT_W){1'b0}}, r_byte_cnt} << 3;
  assign w_byte_inc = (in_last_i && (in_bytes_i != 2'd0)) ? {1'b0, in_bytes_i} : 3'd4;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_dat     = 32'h0;
    w_ready      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next_state = empty_msg_i ? S_PAD80 : S_DATA;
        end
      end
      S_DATA: begin
        w_ready  = !fifo_full_i;
        w_wr_dat = in_dat_i;
        if (in_last_i && (in_bytes_i != 2'd0)) begin
          w_wr_dat = mark_last(in_dat_i, in_bytes_i);
        end
        if (in_valid_i && !fifo_full_i) begin
          w_accept = 1'b1;
          w_wr_en  = 1'b1;
          if (in_last_i) begin
            if (in_bytes_i == 2'd0) begin
              w_next_state = S_PAD80;
            end else begin
              w_next_state = (r_widx == 4'd13) ? S_LENHI : S_ZERO;
            end
          end
        end
      end
      S_PAD80: begin
        w_wr_dat = 32'h8000_0000;
        if (!fifo_full_i) begin
          w_wr_en      = 1'b1;
          w_next_state = (r_widx == 4'd13) ? S_LENHI : S_ZERO;
        end
      end
      S_ZERO: begin
        if (!fifo_full_i) begin
          w_wr_en = 1'b1;
          if (r_widx == 4'd13) begin
            w_next_state = S_LENHI;
          end
        end
      end
      S_LENHI: begin
        w_wr_dat = w_bit_len[63:32];
        if (!fifo_full_i) begin
          w_wr_en      = 1'b1;
          w_next_state = S_LENLO;
        end
      end
      S_LENLO: begin
        w_wr_dat = w_bit_len[31:0];
        if (!fifo_full_i) begin
          w_wr_en      = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Counters: widx tracks the word slot within the current 512-bit block.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_byte_cnt <= '0;
      r_widx     <= 4'd0;
      r_blocks   <= 16'd0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_LENLO) && w_wr_en;
      if ((r_state == S_IDLE) && start_i) begin
        r_byte_cnt <= '0;
        r_widx     <= 4'd0;
        r_blocks   <= 16'd0;
      end else begin
        if (w_accept) begin
          r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(w_byte_inc);
        end
        if (w_wr_en) begin
          r_widx <= r_widx + 4'd1;
          if (r_widx == 4'd15) begin
            r_blocks <= r_blocks + 16'd1;
          end
        end
      end
    end
  end

  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = r_done;
  assign blocks_o      = r_blocks;
  assign in_ready_o    = w_ready;
  assign fifo_wr_en_o  = w_wr_en;
  assign fifo_wr_dat_o = w_wr_dat;

endmodule
